// File: rtl/data_ram_arbiter_pkg.sv
// Shared widths, zero values and arbiter state encoding for the data RAM
// arbiter and its round-robin helper.
package data_ram_arbiter_pkg;

  // Native data RAM geometry.
  localparam int WORD_BUS     = 32;
  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_SEL_BUS  = WORD_BUS / 8;

  localparam logic [WORD_BUS-1:0] ZERO_WORD = '0;

  // Master identifiers as carried in the owner and round-robin registers.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // Sequencer states: waiting, driving the RAM, acknowledging.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // The master that is not m.
  function automatic logic other_master(input logic m);
    return ~m;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. When both masters request,
// rr names the winner; otherwise the sole requester wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic gnt,
  output logic valid
);

  // Pick the granted master and flag whether any request is present.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      gnt = rr;
    end else begin
      gnt = req1;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter and access sequencer for the single-port data RAM.
// Each grant turns into exactly one RAM cycle (ACCESS) followed by a
// one-cycle ack (DONE). Loads capture RAM data into a per-master register
// that holds until the same master's next load completes.
//
// Handshake: a master raises mX_req with its command and holds both until
// mX_ack pulses for one cycle. The command is sampled only on the grant
// edge. During the owner's DONE cycle its req is ignored; a req still high
// in the cycle after ack counts as a fresh request.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS,
  parameter int DATA_W = WORD_BUS,
  parameter int SEL_W  = MEM_SEL_BUS
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [SEL_W-1:0]  ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  output logic [1:0]        dbg_state_o
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [SEL_W-1:0]  cmd_sel_q, cmd_sel_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic in_done;
  logic arb_req0, arb_req1;
  logic arb_gnt, arb_valid;
  logic grant_en;

  // In DONE the owner's req is masked so only the other master can win.
  assign in_done  = (state_q == ARB_DONE);
  assign arb_req0 = m0_req & ~(in_done & (owner_q == OWNER_M0));
  assign arb_req1 = m1_req & ~(in_done & (owner_q == OWNER_M1));

  rr_arb2 u_rr_arb2 (
    .req0  (arb_req0),
    .req1  (arb_req1),
    .rr    (rr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // A grant can only be taken from IDLE or from the DONE handover slot.
  assign grant_en = arb_valid && ((state_q == ARB_IDLE) || (state_q == ARB_DONE));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:   if (arb_valid) state_d = ARB_ACCESS;
      ARB_ACCESS: state_d = ARB_DONE;
      ARB_DONE:   state_d = arb_valid ? ARB_ACCESS : ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Next values for owner, round-robin pointer, latched command and rdata.
  always_comb begin
    owner_d     = owner_q;
    rr_d        = rr_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_wdata_d = cmd_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    // The master just served loses the next tie.
    if (state_q == ARB_DONE) begin
      rr_d = other_master(owner_q);
    end

    // Command inputs are sampled only here; later changes are ignored.
    if (grant_en) begin
      owner_d = arb_gnt;
      if (arb_gnt == OWNER_M1) begin
        cmd_we_d    = m1_we;
        cmd_addr_d  = m1_addr;
        cmd_sel_d   = m1_sel;
        cmd_wdata_d = m1_wdata;
      end else begin
        cmd_we_d    = m0_we;
        cmd_addr_d  = m0_addr;
        cmd_sel_d   = m0_sel;
        cmd_wdata_d = m0_wdata;
      end
    end

    // Loads capture the combinational RAM data at the end of ACCESS.
    if ((state_q == ARB_ACCESS) && !cmd_we_q) begin
      if (owner_q == OWNER_M1) begin
        m1_rdata_d = ram_rdata;
      end else begin
        m0_rdata_d = ram_rdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWNER_M0;
      rr_q        <= OWNER_M0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_sel_q   <= '0;
      cmd_wdata_q <= DATA_W'(ZERO_WORD);
      m0_rdata_q  <= DATA_W'(ZERO_WORD);
      m1_rdata_q  <= DATA_W'(ZERO_WORD);
    end else begin
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_wdata_q <= cmd_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // FSM outputs: RAM pins live only in ACCESS, acks only in DONE.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = DATA_W'(ZERO_WORD);
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    if (state_q == ARB_ACCESS) begin
      ram_we    = cmd_we_q;
      ram_re    = ~cmd_we_q;
      ram_addr  = cmd_addr_q;
      ram_sel   = cmd_sel_q;
      ram_wdata = cmd_wdata_q;
    end
    if (state_q == ARB_DONE) begin
      m0_ack = (owner_q == OWNER_M0);
      m1_ack = (owner_q == OWNER_M1);
    end
  end

  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign dbg_state_o = state_q;

endmodule
